// File: rtl/sr_latch_exerciser_if.sv
// sr_latch_if: drive/observe bundle between the exerciser and an enabled active-low SR latch
interface sr_latch_if;
  logic S;
  logic R;
  logic E;
  logic Q;
  logic Q_Inverter;
  modport master (output S, R, E, input Q, Q_Inverter);
  modport slave (input S, R, E, output Q, Q_Inverter);
endinterface

// File: rtl/sr_latch_exerciser.sv
// sr_latch_exerciser: plays a 7-step vector sequence into an SR latch and counts output mismatches
module sr_latch_exerciser #(
  parameter int HOLD_CYCLES = 100,
  parameter int CNT_W = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic START,
  sr_latch_if.master lat,
  output logic BUSY,
  output logic DONE,
  output logic PASS,
  output logic [3:0] ERR_COUNT,
  output logic [2:0] STEP
);
  typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;
  // {E,S,R} per step, step 0 in the low bits
  localparam logic [20:0] VEC = {3'b001, 3'b111, 3'b110, 3'b010, 3'b111, 3'b101, 3'b011};
  // expected Q per step, bit i = step i (step 0 unchecked)
  localparam logic [6:0] EXPQ = 7'b0001110;
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0] r_step;
  logic [3:0] r_err;
  logic r_e, r_s, r_r, r_busy, r_done, r_pass;
  logic w_last, w_mis;
  logic [2:0] w_nstep, w_nvec;
  logic [3:0] w_err;
  assign w_last = r_cnt == CNT_W'(HOLD_CYCLES - 1);
  assign w_nstep = r_step + 3'd1;
  assign w_nvec = VEC[{2'b00, w_nstep} * 5'd3 +: 3];
  assign w_mis = (r_step != 3'd0) && ((lat.Q !== EXPQ[r_step]) || (lat.Q_Inverter !== ~lat.Q));
  assign w_err = (w_mis && r_err != 4'hF) ? r_err + 4'd1 : r_err;
  assign lat.E = r_e;
  assign lat.S = r_s;
  assign lat.R = r_r;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign PASS = r_pass;
  assign ERR_COUNT = r_err;
  assign STEP = r_step;
  // sequencer: start/restart, per-step hold counting, end-of-hold check and step advance
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      {r_e, r_s, r_r} <= 3'b011;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err <= 4'd0;
      r_step <= 3'd0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE, FINISH: if (START) begin
          r_state <= DRIVE;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_pass <= 1'b0;
          r_err <= 4'd0;
          r_step <= 3'd0;
          r_cnt <= '0;
          {r_e, r_s, r_r} <= VEC[2:0];
        end
        DRIVE: if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
        else begin
          r_err <= w_err;
          r_cnt <= '0;
          if (r_step == 3'd6) begin
            r_state <= FINISH;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= w_err == 4'd0;
            {r_e, r_s, r_r} <= 3'b011;
          end else begin
            r_step <= w_nstep;
            {r_e, r_s, r_r} <= w_nvec;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_latch_exerciser.sv
// tb_sr_latch_exerciser: table-driven runs against a behavioural latch with fault modes, plus corner sequences
module tb_sr_latch_exerciser;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;
  logic BUSY, DONE, PASS;
  logic [3:0] ERR_COUNT;
  logic [2:0] STEP;
  logic [1:0] mode = 2'd0;
  logic q_m;
  int tests = 0;
  int failed = 0;
  sr_latch_if lat ();
  sr_latch_exerciser #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .lat(lat),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_COUNT(ERR_COUNT), .STEP(STEP)
  );
  always #5 CLK = ~CLK;
  // behavioural enabled active-low SR latch
  always_latch if (lat.E) begin
    if (!lat.S) q_m <= 1'b1;
    else if (!lat.R) q_m <= 1'b0;
  end
  // mode 0: correct, 1: Q stuck 0 / Qn stuck 1, 2: Qn tied to Q
  assign lat.Q = (mode == 2'd1) ? 1'b0 : q_m;
  assign lat.Q_Inverter = (mode == 2'd0) ? ~q_m : (mode == 2'd1) ? 1'b1 : q_m;
  typedef struct {logic [1:0] mode; logic [3:0] err; logic pass;} vec_t;
  vec_t vecs[6];
  logic [2:0] esr_tb[7];
  logic [4:0] sb[$];
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while (!DONE && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("done_timeout", int'(DONE), 1);
  endtask
  task automatic run_seq(input logic [3:0] e_err, input logic e_pass, input int poke);
    int n = 0;
    logic [4:0] ex;
    sb.push_back({e_err, e_pass});
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    while (BUSY && n < 200) begin
      chk("step", int'(STEP), n / 4);
      chk("esr", int'({lat.E, lat.S, lat.R}), int'(esr_tb[n / 4]));
      START = (n == poke);
      @(negedge CLK);
      n++;
    end
    START = 1'b0;
    chk("busy_len", n, 28);
    chk("done", int'(DONE), 1);
    ex = sb.pop_front();
    chk("err_count", int'(ERR_COUNT), int'(ex[4:1]));
    chk("pass", int'(PASS), int'(ex[0]));
  endtask
  initial begin
    esr_tb = '{3'b011, 3'b101, 3'b111, 3'b010, 3'b110, 3'b111, 3'b001};
    vecs = '{'{2'd0, 4'd0, 1'b1}, '{2'd1, 4'd3, 1'b0}, '{2'd2, 4'd6, 1'b0},
             '{2'd0, 4'd0, 1'b1}, '{2'd2, 4'd6, 1'b0}, '{2'd2, 4'd6, 1'b0}};
    repeat (2) @(negedge CLK);
    chk("rst_esr", int'({lat.E, lat.S, lat.R}), 3);
    chk("rst_flags", int'({BUSY, DONE, PASS}), 0);
    chk("rst_err", int'(ERR_COUNT), 0);
    chk("rst_step", int'(STEP), 0);
    RST = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode;
      run_seq(vecs[i].err, vecs[i].pass, (i == 3) ? 9 : -1);
    end
    // restart from a failing FINISH clears the count
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    chk("restart_done", int'(DONE), 0);
    chk("restart_err", int'(ERR_COUNT), 0);
    chk("restart_busy", int'(BUSY), 1);
    // asynchronous reset mid step 3
    repeat (12) @(negedge CLK);
    chk("mid_step", int'(STEP), 3);
    #2 RST = 1'b1;
    #1;
    chk("arst_esr", int'({lat.E, lat.S, lat.R}), 3);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_err", int'(ERR_COUNT), 0);
    chk("arst_step", int'(STEP), 0);
    @(negedge CLK) RST = 1'b0;
    mode = 2'd0;
    run_seq(4'd0, 1'b1, -1);
    // START held high in FINISH restarts once per completion
    @(negedge CLK) START = 1'b1;
    @(negedge CLK);
    chk("held_busy1", int'(BUSY), 1);
    wait_done();
    @(negedge CLK);
    chk("held_rerun", int'(BUSY), 1);
    START = 1'b0;
    wait_done();
    repeat (3) @(negedge CLK);
    chk("held_stays_done", int'({BUSY, DONE}), 1);
    // saturation: preload 15 mid step 1, then further mismatches must not wrap
    mode = 2'd2;
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    repeat (5) @(negedge CLK);
    force dut.r_err = 4'd15;
    @(negedge CLK);
    release dut.r_err;
    wait_done();
    chk("sat_err", int'(ERR_COUNT), 15);
    chk("sat_pass", int'(PASS), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
